pciedma_csr: RTL and testbench

Parametrised slave-bus CSR and descriptor-issue block for the PCIe DMA path. It replaces the single fixed segment-LED register on BAR0 with NUM_CH DMA channels, each programmed through the slave bus. A round-robin arbiter serialises started channels into 4-word descriptors on the 18-bit master queue (wr_mstq) interface. It also reports per-channel done status and raises an interrupt pulse.

---
 rtl/pciedma_pkg.sv | 44 ++++
 rtl/rr_arbiter.sv | 30 +++
 rtl/pciedma_csr.sv | 204 ++++++++++++++++++++
 tb/tb_pciedma_csr.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pciedma_pkg.sv
// Shared definitions for the PCIe DMA CSR block: register map,
// CTRL bit positions, descriptor framing bits and FSM encoding.
package pciedma_pkg;

  // Each channel occupies four consecutive 16-bit word registers
  localparam int CH_STRIDE = 4;

  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_ADDR_LO = 2'd1;
  localparam logic [1:0] OFF_ADDR_HI = 2'd2;
  localparam logic [1:0] OFF_LEN     = 2'd3;

  localparam logic [8:0] REG_DONE   = 9'h100;
  localparam logic [8:0] REG_SEGLED = 9'h101;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ERR    = 14;
  localparam int CTRL_BUSY   = 15;

  // Framing bits on the 18-bit master queue word
  localparam int SOF_BIT = 17;
  localparam int EOF_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3
  } dma_state_e;

  // Merge a 16-bit write into an existing value under byte enables
  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] wr_val,
                                             input logic [1:0]  sel);
    logic [15:0] res;
    res = old_val;
    if (sel[0]) res[7:0]  = wr_val[7:0];
    if (sel[1]) res[15:8] = wr_val[15:8];
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requesting channel at or after
// the pointer, wrapping around, and reports it one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     grant_idx,
  output logic              grant_valid
);

  // Scan offsets from the pointer outward; the first hit wins
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!grant_valid && req[j] && (j == (int'(ptr) + i) % NUM_CH)) begin
          grant[j]    = 1'b1;
          grant_idx   = CW'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pciedma_csr.sv
// Slave-bus CSR block for the PCIe DMA path: per-channel DMA registers,
// DONE/SEGLED globals, and a round-robin descriptor issuer that pushes
// 4-word descriptors into the master queue.
module pciedma_csr #(
  parameter int          NUM_CH  = 4,
  parameter int          BAR_IDX = 0,
  parameter logic [13:0] SEG_RST = 14'h3fff
) (
  input  logic              pcie_clk,
  input  logic              sys_rst_n,
  input  logic [6:0]        slv_bar_i,
  input  logic              slv_ce_i,
  input  logic              slv_we_i,
  input  logic [19:1]       slv_adr_i,
  input  logic [15:0]       slv_dat_i,
  input  logic [1:0]        slv_sel_i,
  output logic [15:0]       slv_dat_o,
  output logic [17:0]       mst_din,
  output logic              mst_wr_en,
  input  logic              mst_full,
  output logic [NUM_CH-1:0] irq,
  output logic [13:0]       segled
);
  import pciedma_pkg::*;

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              acc, wr, rd, ch_hit, ch_wr;
  logic [8:0]        idx;
  logic [CW-1:0]     ch_sel;
  logic [1:0]        ch_off;

  logic [15:0]       addr_lo [NUM_CH];
  logic [15:0]       addr_hi [NUM_CH];
  logic [15:0]       len     [NUM_CH];
  logic [NUM_CH-1:0] busy, err, irq_en, issued, done;

  dma_state_e        state;
  logic [CW-1:0]     cur_ch, rr_ptr;
  logic [NUM_CH-1:0] grant_oh;
  logic [CW-1:0]     grant_idx;
  logic              grant_valid, grant_take, desc_done;
  logic [NUM_CH-1:0] fin_vec, done_clr;
  logic [15:0]       w1c_mask, rd_data;
  logic [3:0]        ch_nib;
  logic              unused_bits;

  assign acc    = slv_bar_i[BAR_IDX] & slv_ce_i;
  assign wr     = acc & slv_we_i;
  assign rd     = acc & ~slv_we_i;
  assign idx    = slv_adr_i[9:1];
  assign ch_hit = (idx < 9'(CH_STRIDE * NUM_CH));
  assign ch_wr  = wr & ch_hit;
  assign ch_sel = idx[CW+1:2];
  assign ch_off = idx[1:0];
  assign ch_nib = 4'(cur_ch);

  assign unused_bits = ^{slv_adr_i[19:17], slv_bar_i, grant_oh};

  assign grant_take = (state == ST_IDLE) && grant_valid;
  assign desc_done  = (state == ST_W3) && !mst_full;
  assign mst_wr_en  = (state != ST_IDLE) && !mst_full;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_arb (
    .req         (busy & ~issued),
    .ptr         (rr_ptr),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Completion vector and software W1C mask for the DONE register
  always_comb begin
    fin_vec = '0;
    if (desc_done) fin_vec[cur_ch] = 1'b1;
    w1c_mask = {slv_sel_i[1] ? slv_dat_i[15:8] : 8'h00,
                slv_sel_i[0] ? slv_dat_i[7:0]  : 8'h00};
    done_clr = (wr && idx == REG_DONE) ? w1c_mask[NUM_CH-1:0] : '0;
  end

  // Descriptor word is a pure function of the FSM state and active channel
  always_comb begin
    mst_din = '0;
    case (state)
      ST_W0: begin
        mst_din          = 18'(ch_nib);
        mst_din[SOF_BIT] = 1'b1;
      end
      ST_W1: mst_din = 18'(addr_lo[cur_ch]);
      ST_W2: mst_din = 18'(addr_hi[cur_ch]);
      ST_W3: begin
        mst_din          = 18'(len[cur_ch]);
        mst_din[EOF_BIT] = 1'b1;
      end
      default: mst_din = '0;
    endcase
  end

  // Channel registers, START handling, DONE/IRQ and SEGLED updates
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        addr_lo[c] <= '0;
        addr_hi[c] <= '0;
        len[c]     <= '0;
      end
      busy   <= '0;
      err    <= '0;
      irq_en <= '0;
      issued <= '0;
      done   <= '0;
      irq    <= '0;
      segled <= SEG_RST;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_wr && ch_sel == CW'(c)) begin
          case (ch_off)
            OFF_CTRL: begin
              if (slv_sel_i[0] && !busy[c]) begin
                irq_en[c] <= slv_dat_i[CTRL_IRQ_EN];
                if (slv_dat_i[CTRL_START]) begin
                  if (len[c] == 16'h0) begin
                    err[c] <= 1'b1;
                  end else begin
                    busy[c]   <= 1'b1;
                    err[c]    <= 1'b0;
                    issued[c] <= 1'b0;
                  end
                end
              end
            end
            OFF_ADDR_LO: if (!busy[c]) addr_lo[c] <= byte_merge(addr_lo[c], slv_dat_i, slv_sel_i);
            OFF_ADDR_HI: if (!busy[c]) addr_hi[c] <= byte_merge(addr_hi[c], slv_dat_i, slv_sel_i);
            OFF_LEN:     if (!busy[c]) len[c]     <= byte_merge(len[c], slv_dat_i, slv_sel_i);
            default: ;
          endcase
        end
        if (grant_take && grant_idx == CW'(c)) issued[c] <= 1'b1;
        if (fin_vec[c]) busy[c] <= 1'b0;
      end
      done <= (done & ~done_clr) | fin_vec;
      irq  <= fin_vec & irq_en;
      if (wr && idx == REG_SEGLED) begin
        if (slv_sel_i[0]) segled[7:0]  <= slv_dat_i[7:0];
        if (slv_sel_i[1]) segled[13:8] <= slv_dat_i[13:8];
      end
    end
  end

  // Issue FSM: grant a pending channel, then walk the four descriptor words
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= ST_IDLE;
      cur_ch <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur_ch <= grant_idx;
            rr_ptr <= (grant_idx == CW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            state  <= ST_W0;
          end
        end
        ST_W0:   if (!mst_full) state <= ST_W1;
        ST_W1:   if (!mst_full) state <= ST_W2;
        ST_W2:   if (!mst_full) state <= ST_W3;
        ST_W3:   if (!mst_full) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read mux; unmapped addresses echo the low address bits
  always_comb begin
    rd_data = slv_adr_i[16:1];
    if (ch_hit) begin
      case (ch_off)
        OFF_CTRL:    rd_data = {busy[ch_sel], err[ch_sel], 12'h000, irq_en[ch_sel], 1'b0};
        OFF_ADDR_LO: rd_data = addr_lo[ch_sel];
        OFF_ADDR_HI: rd_data = addr_hi[ch_sel];
        OFF_LEN:     rd_data = len[ch_sel];
        default:     rd_data = slv_adr_i[16:1];
      endcase
    end else if (idx == REG_DONE) begin
      rd_data = 16'(done);
    end else if (idx == REG_SEGLED) begin
      rd_data = {2'b00, segled};
    end
  end

  // Registered read data, held between read accesses
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slv_dat_o <= '0;
    end else if (rd) begin
      slv_dat_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_pciedma_csr.sv
// Scoreboard bench for pciedma_csr: expected descriptor words are queued
// when START is written and compared as the DUT pushes them.
`timescale 1ns/1ps
module tb_pciedma_csr;

  localparam int NUM_CH = 4;

  logic              pcie_clk = 1'b0;
  logic              sys_rst_n;
  logic [6:0]        slv_bar_i;
  logic              slv_ce_i;
  logic              slv_we_i;
  logic [19:1]       slv_adr_i;
  logic [15:0]       slv_dat_i;
  logic [1:0]        slv_sel_i;
  logic [15:0]       slv_dat_o;
  logic [17:0]       mst_din;
  logic              mst_wr_en;
  logic              mst_full;
  logic [NUM_CH-1:0] irq;
  logic [13:0]       segled;

  typedef struct {
    logic [17:0] word;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cycle    = 0;

  pciedma_csr #(
    .NUM_CH  (NUM_CH),
    .BAR_IDX (0),
    .SEG_RST (14'h3fff)
  ) dut (
    .pcie_clk  (pcie_clk),
    .sys_rst_n (sys_rst_n),
    .slv_bar_i (slv_bar_i),
    .slv_ce_i  (slv_ce_i),
    .slv_we_i  (slv_we_i),
    .slv_adr_i (slv_adr_i),
    .slv_dat_i (slv_dat_i),
    .slv_sel_i (slv_sel_i),
    .slv_dat_o (slv_dat_o),
    .mst_din   (mst_din),
    .mst_wr_en (mst_wr_en),
    .mst_full  (mst_full),
    .irq       (irq),
    .segled    (segled)
  );

  always #5 pcie_clk = ~pcie_clk;

  // Cycle counter used to time descriptor pushes
  always @(posedge pcie_clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare every pushed word against the queue head
  always @(negedge pcie_clk) begin
    if (mst_wr_en) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_push", 32'(mst_wr_en), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("desc_word", 32'(mst_din), 32'(e.word));
        if (e.cyc >= 0) checkOutput("desc_cycle", 32'(cycle), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] idx, input logic [15:0] dat,
                               input logic [1:0] sel = 2'b11);
    slv_ce_i  = 1'b1;
    slv_we_i  = 1'b1;
    slv_adr_i = {10'd0, idx};
    slv_dat_i = dat;
    slv_sel_i = sel;
    tick();
    slv_ce_i  = 1'b0;
    slv_we_i  = 1'b0;
  endtask

  task automatic readRegister(input logic [18:0] adr, output logic [15:0] val);
    slv_ce_i  = 1'b1;
    slv_we_i  = 1'b0;
    slv_adr_i = adr;
    tick();
    slv_ce_i  = 1'b0;
    val       = slv_dat_o;
  endtask

  task automatic readCheck(input string tag, input logic [8:0] idx, input logic [15:0] exp);
    logic [15:0] v;
    readRegister({10'd0, idx}, v);
    checkOutput(tag, 32'(v), 32'(exp));
  endtask

  task automatic pushWord(input logic [17:0] w, input int cyc);
    exp_t e;
    e.word = w;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Queue a whole descriptor; t0 < 0 means timing is not checked
  task automatic pushDesc(input int ch, input logic [15:0] lo, input logic [15:0] hi,
                          input logic [15:0] ln, input int t0);
    pushWord({2'b10, 12'h000, 4'(ch)}, (t0 < 0) ? -1 : t0 + 2);
    pushWord({2'b00, lo},              (t0 < 0) ? -1 : t0 + 3);
    pushWord({2'b00, hi},              (t0 < 0) ? -1 : t0 + 4);
    pushWord({2'b01, ln},              (t0 < 0) ? -1 : t0 + 5);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    checkOutput(tag, 32'(exp_q.size()), 32'h0);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int t;
    sys_rst_n = 1'b0;
    slv_bar_i = 7'b0000001;
    slv_ce_i  = 1'b0;
    slv_we_i  = 1'b0;
    slv_adr_i = '0;
    slv_dat_i = '0;
    slv_sel_i = 2'b11;
    mst_full  = 1'b0;
    tick();
    tick();

    checkOutput("rst_dat_o",  32'(slv_dat_o), 32'h0);
    checkOutput("rst_wr_en",  32'(mst_wr_en), 32'h0);
    checkOutput("rst_din",    32'(mst_din),   32'h0);
    checkOutput("rst_irq",    32'(irq),       32'h0);
    checkOutput("rst_segled", 32'(segled),    32'h3fff);
    sys_rst_n = 1'b1;
    tick();

    $display("[TB] SEGLED byte-enable write");
    applyStimulus(9'h101, 16'h00AA, 2'b01);
    checkOutput("segled_sel", 32'(segled), 32'h3faa);
    readCheck("segled_rd", 9'h101, 16'h3faa);

    $display("[TB] channel 1 descriptor with IRQ");
    applyStimulus(9'd5, 16'h1234);
    applyStimulus(9'd6, 16'h0001);
    applyStimulus(9'd7, 16'h0040);
    applyStimulus(9'd4, 16'h0002);
    t = cycle;
    pushDesc(1, 16'h1234, 16'h0001, 16'h0040, t);
    applyStimulus(9'd4, 16'h0003);
    readCheck("ch1_ctrl_busy", 9'd4, 16'h8002);
    repeat (3) tick();
    checkOutput("irq_t5", 32'(irq), 32'h0);
    tick();
    checkOutput("irq_t6", 32'(irq), 32'h2);
    tick();
    checkOutput("irq_t7", 32'(irq), 32'h0);
    readCheck("done_ch1", 9'h100, 16'h0002);
    readCheck("ch1_ctrl_done", 9'd4, 16'h0002);
    waitDrain("drain_ch1");

    $display("[TB] round-robin ordering");
    applyStimulus(9'd1,  16'h1000);
    applyStimulus(9'd2,  16'h0010);
    applyStimulus(9'd3,  16'h0008);
    applyStimulus(9'd9,  16'h2000);
    applyStimulus(9'd10, 16'h0020);
    applyStimulus(9'd11, 16'h0010);
    applyStimulus(9'd13, 16'h3000);
    applyStimulus(9'd14, 16'h0030);
    applyStimulus(9'd15, 16'h0018);
    pushDesc(0, 16'h1000, 16'h0010, 16'h0008, -1);
    pushDesc(2, 16'h2000, 16'h0020, 16'h0010, -1);
    pushDesc(3, 16'h3000, 16'h0030, 16'h0018, -1);
    applyStimulus(9'd0,  16'h0001);
    applyStimulus(9'd8,  16'h0001);
    applyStimulus(9'd12, 16'h0001);
    waitDrain("drain_order");

    // ch2 is granted alone (pointer moves to 3); ch3 then beats ch0
    mst_full = 1'b1;
    pushDesc(2, 16'h2000, 16'h0020, 16'h0010, -1);
    pushDesc(3, 16'h3000, 16'h0030, 16'h0018, -1);
    pushDesc(0, 16'h1000, 16'h0010, 16'h0008, -1);
    applyStimulus(9'd8,  16'h0001);
    applyStimulus(9'd0,  16'h0001);
    applyStimulus(9'd12, 16'h0001);
    tick();
    mst_full = 1'b0;
    waitDrain("drain_rr");

    $display("[TB] back-pressure during W1");
    t = cycle;
    pushWord(18'h20001, t + 2);
    pushWord(18'h01234, t + 13);
    pushWord(18'h00001, t + 14);
    pushWord(18'h10040, t + 15);
    applyStimulus(9'd4, 16'h0003);
    tick();
    tick();
    mst_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge pcie_clk);
      checkOutput("stall_wr_en", 32'(mst_wr_en), 32'h0);
      checkOutput("stall_din",   32'(mst_din),   32'h01234);
      tick();
    end
    mst_full = 1'b0;
    waitDrain("drain_stall");

    $display("[TB] zero-length START");
    applyStimulus(9'd15, 16'h0000);
    applyStimulus(9'd12, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      checkOutput("len0_wr_en", 32'(mst_wr_en), 32'h0);
      tick();
    end
    readCheck("ch3_ctrl_err", 9'd12, 16'h4000);
    applyStimulus(9'd15, 16'h0005);
    t = cycle;
    pushDesc(3, 16'h3000, 16'h0030, 16'h0005, t);
    applyStimulus(9'd12, 16'h0001);
    readCheck("ch3_ctrl_busy", 9'd12, 16'h8000);
    waitDrain("drain_len0");
    readCheck("ch3_ctrl_clr", 9'd12, 16'h0000);

    $display("[TB] DONE set vs W1C collision");
    t = cycle;
    pushDesc(0, 16'h1000, 16'h0010, 16'h0008, t);
    applyStimulus(9'd0, 16'h0001);
    repeat (4) tick();
    applyStimulus(9'h100, 16'hFFFF);
    readCheck("done_race", 9'h100, 16'h0001);
    waitDrain("drain_race");

    $display("[TB] reset during W2");
    t = cycle;
    pushDesc(2, 16'h2000, 16'h0020, 16'h0010, t);
    applyStimulus(9'd8, 16'h0001);
    repeat (3) tick();
    checkOutput("pre_rst_wr_en", 32'(mst_wr_en), 32'h1);
    checkOutput("pre_rst_din",   32'(mst_din),   32'h00020);
    sys_rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en", 32'(mst_wr_en), 32'h0);
    checkOutput("mid_rst_din",   32'(mst_din),   32'h0);
    exp_q.delete();
    tick();
    tick();
    sys_rst_n = 1'b1;
    tick();
    for (int r = 0; r < 4 * NUM_CH; r++) readCheck("post_rst_ch_reg", 9'(r), 16'h0000);
    readCheck("post_rst_done",   9'h100, 16'h0000);
    readCheck("post_rst_segled", 9'h101, 16'h3fff);
    checkOutput("post_rst_segled_port", 32'(segled), 32'h3fff);
    begin
      logic [15:0] v;
      readRegister(19'h12345, v);
      checkOutput("unmapped_rd", 32'(v), 32'h2345);
    end
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
